// File: rtl/core_pkg.sv
// Shared core definitions: PC control encodings used by `pc` and the fetch
// sequencer state type.
package core_pkg;

  localparam int PC_CTRL_WIDTH = 2;

  localparam logic [PC_CTRL_WIDTH-1:0] PC_INC  = 2'd0;
  localparam logic [PC_CTRL_WIDTH-1:0] PC_SET  = 2'd1;
  localparam logic [PC_CTRL_WIDTH-1:0] PC_ADD  = 2'd2;
  localparam logic [PC_CTRL_WIDTH-1:0] PC_COND = 2'd3;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } pc_seq_state_t;

  function automatic logic is_redirect(input logic                     valid,
                                       input logic [PC_CTRL_WIDTH-1:0] ctrl,
                                       input logic                     taken);
    return valid & ((ctrl == PC_SET) | (ctrl == PC_ADD) |
                    ((ctrl == PC_COND) & taken));
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch/PC sequencing controller: single-outstanding imem fetch handshake,
// PC increment/redirect pulses to `pc`, and wrong-path flush/drain.
module pc_sequencer
  import core_pkg::*;
#(
  parameter int unsigned BootCycles = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     imem_req_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic                     stall_i,
  input  logic                     exe_valid_i,
  input  logic [PC_CTRL_WIDTH-1:0] exe_ctrl_i,
  input  logic                     exe_taken_i,
  output logic                     pc_en_o,
  output logic [PC_CTRL_WIDTH-1:0] pc_ctrl_o,
  output logic                     flush_o,
  output logic                     fetch_valid_o,
  output logic [31:0]              fetch_cnt_o
);

  localparam logic [3:0] BootLast = 4'(BootCycles - 1);

  pc_seq_state_t state;
  pc_seq_state_t state_nxt;
  logic [3:0]    boot_cnt;
  logic          redirect;
  logic          accept;

  assign redirect = is_redirect(exe_valid_i, exe_ctrl_i, exe_taken_i);

  // Outputs are combinational from state and inputs; reset masks them so the
  // pc block sees nothing while the sequencer is being forced back to BOOT.
  always_comb begin
    imem_req_o    = 1'b0;
    pc_en_o       = 1'b0;
    pc_ctrl_o     = PC_INC;
    flush_o       = 1'b0;
    fetch_valid_o = 1'b0;
    accept        = 1'b0;
    if (!rst_i && state != BOOT) begin
      if (redirect) begin
        pc_en_o   = 1'b1;
        pc_ctrl_o = exe_ctrl_i;
        flush_o   = 1'b1;
      end else begin
        unique case (state)
          FETCH: imem_req_o = 1'b1;
          WAIT: begin
            fetch_valid_o = imem_rvalid_i;
            accept        = imem_rvalid_i & ~stall_i;
          end
          HOLD: begin
            fetch_valid_o = 1'b1;
            accept        = ~stall_i;
          end
          default: ;
        endcase
        pc_en_o = accept;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT: begin
        if (boot_cnt == BootLast) state_nxt = FETCH;
      end
      FETCH: begin
        if (!redirect && imem_gnt_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect)           state_nxt = imem_rvalid_i ? FETCH : DRAIN;
        else if (imem_rvalid_i) state_nxt = stall_i ? HOLD : FETCH;
      end
      HOLD: begin
        if (redirect || !stall_i) state_nxt = FETCH;
      end
      DRAIN: begin
        if (imem_rvalid_i) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      fetch_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == BOOT && boot_cnt != BootLast) boot_cnt <= boot_cnt + 4'd1;
      if (accept) fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, straight-line fetch, stall, redirects,
// drain and reset mid-hold, with hand-computed expected outputs.
module tb_pc_sequencer;
  import core_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     imem_req_o;
  logic                     imem_gnt_i;
  logic                     imem_rvalid_i;
  logic                     stall_i;
  logic                     exe_valid_i;
  logic [PC_CTRL_WIDTH-1:0] exe_ctrl_i;
  logic                     exe_taken_i;
  logic                     pc_en_o;
  logic [PC_CTRL_WIDTH-1:0] pc_ctrl_o;
  logic                     flush_o;
  logic                     fetch_valid_o;
  logic [31:0]              fetch_cnt_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pc_sequencer #(.BootCycles(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .stall_i       (stall_i),
    .exe_valid_i   (exe_valid_i),
    .exe_ctrl_i    (exe_ctrl_i),
    .exe_taken_i   (exe_taken_i),
    .pc_en_o       (pc_en_o),
    .pc_ctrl_o     (pc_ctrl_o),
    .flush_o       (flush_o),
    .fetch_valid_o (fetch_valid_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Bench must never violate the fetch protocol.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      assert (!(imem_gnt_i && !imem_req_o))
        else $error("protocol: gnt without req");
      assert (!(imem_rvalid_i && (dut.state == FETCH || dut.state == HOLD)))
        else $error("protocol: rvalid in FETCH/HOLD");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // {req, en, ctrl[1:0], flush, fetch_valid}
  function automatic logic [5:0] o(input logic req, input logic en,
                                   input logic [1:0] ctrl, input logic fl,
                                   input logic fv);
    return {req, en, ctrl, fl, fv};
  endfunction

  // Drive one cycle of inputs, check the combinational outputs mid-cycle,
  // then advance past the next rising edge.
  task automatic step(input string tag, input logic gnt, input logic rv,
                      input logic st, input logic ev, input logic [1:0] ec,
                      input logic tk, input logic [5:0] exp);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    stall_i       = st;
    exe_valid_i   = ev;
    exe_ctrl_i    = ec;
    exe_taken_i   = tk;
    #2;
    check_eq(tag, {26'd0, imem_req_o, pc_en_o, pc_ctrl_o, flush_o, fetch_valid_o},
             {26'd0, exp});
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    imem_gnt_i = 0; imem_rvalid_i = 0; stall_i = 0;
    exe_valid_i = 0; exe_ctrl_i = PC_INC; exe_taken_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    step("reset_out", 0, 0, 0, 1, PC_SET, 0, o(0, 0, PC_INC, 0, 0));
    check_eq("reset_cnt", fetch_cnt_o, 32'd0);
    rst_i = 1'b0;

    // Boot: two idle cycles, request in the third.
    step("boot1", 0, 0, 0, 1, PC_SET, 0, o(0, 0, PC_INC, 0, 0));
    step("boot2", 0, 0, 0, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 0));

    // Straight line: 8 instructions, 2 cycles each.
    for (int i = 0; i < 8; i++) begin
      step("line_fetch", 1, 0, 0, 0, PC_INC, 0, o(1, 0, PC_INC, 0, 0));
      step("line_wait",  0, 1, 0, 0, PC_INC, 0, o(0, 1, PC_INC, 0, 1));
    end
    check_eq("line_cnt", fetch_cnt_o, 32'd8);

    // Stall for 3 cycles: valid held 4 cycles, one pulse on release.
    step("stall_fetch", 1, 0, 0, 0, PC_INC, 0, o(1, 0, PC_INC, 0, 0));
    step("stall_wait",  0, 1, 1, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 1));
    step("stall_hold1", 0, 0, 1, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 1));
    step("stall_hold2", 0, 0, 1, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 1));
    check_eq("stall_cnt_held", fetch_cnt_o, 32'd8);
    step("stall_rel",   0, 0, 0, 0, PC_INC, 0, o(0, 1, PC_INC, 0, 1));
    check_eq("stall_cnt", fetch_cnt_o, 32'd9);

    // Taken branch in WAIT, then drain the late response.
    step("br_fetch", 1, 0, 0, 0, PC_INC,  0, o(1, 0, PC_INC, 0, 0));
    step("br_wait",  0, 0, 0, 1, PC_COND, 1, o(0, 1, PC_COND, 1, 0));
    step("br_drain", 0, 1, 0, 0, PC_INC,  0, o(0, 0, PC_INC, 0, 0));
    // Not-taken COND and INC from EXE are ignored in FETCH.
    step("nt_cond",  0, 0, 0, 1, PC_COND, 0, o(1, 0, PC_INC, 0, 0));
    step("nt_inc",   0, 0, 0, 1, PC_INC,  1, o(1, 0, PC_INC, 0, 0));
    // Redirect in FETCH drops the request for that cycle.
    step("fetch_redir", 0, 0, 0, 1, PC_ADD, 0, o(0, 1, PC_ADD, 1, 0));
    check_eq("br_cnt", fetch_cnt_o, 32'd9);

    // Redirect coincident with rvalid: data discarded, back to FETCH.
    step("sim_fetch", 1, 0, 0, 0, PC_INC, 0, o(1, 0, PC_INC, 0, 0));
    step("sim_wait",  0, 1, 0, 1, PC_SET, 0, o(0, 1, PC_SET, 1, 0));
    check_eq("sim_cnt", fetch_cnt_o, 32'd9);

    // Back-to-back redirects, one drained response.
    step("b2b_fetch",  1, 0, 0, 0, PC_INC, 0, o(1, 0, PC_INC, 0, 0));
    step("b2b_wait",   0, 0, 0, 1, PC_ADD, 0, o(0, 1, PC_ADD, 1, 0));
    step("b2b_drain1", 0, 0, 0, 1, PC_SET, 0, o(0, 1, PC_SET, 1, 0));
    step("b2b_drain2", 0, 1, 0, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 0));

    // Redirect in DRAIN together with rvalid returns straight to FETCH.
    step("dr_fetch", 1, 0, 0, 0, PC_INC,  0, o(1, 0, PC_INC, 0, 0));
    step("dr_wait",  0, 0, 0, 1, PC_ADD,  0, o(0, 1, PC_ADD, 1, 0));
    step("dr_both",  0, 1, 0, 1, PC_COND, 1, o(0, 1, PC_COND, 1, 0));

    // Redirect in HOLD discards the held instruction.
    step("hr_fetch", 1, 0, 0, 0, PC_INC, 0, o(1, 0, PC_INC, 0, 0));
    step("hr_wait",  0, 1, 1, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 1));
    step("hr_hold",  0, 0, 1, 1, PC_SET, 0, o(0, 1, PC_SET, 1, 0));
    check_eq("hr_cnt", fetch_cnt_o, 32'd9);

    // Reset mid-HOLD; a stale rvalid during BOOT is ignored.
    step("rh_fetch", 1, 0, 0, 0, PC_INC, 0, o(1, 0, PC_INC, 0, 0));
    step("rh_wait",  0, 1, 1, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 1));
    rst_i = 1'b1;
    step("rh_rst",   0, 0, 0, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 0));
    rst_i = 1'b0;
    check_eq("rh_cnt0", fetch_cnt_o, 32'd0);
    step("rh_boot1", 0, 1, 0, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 0));
    step("rh_boot2", 0, 0, 0, 0, PC_INC, 0, o(0, 0, PC_INC, 0, 0));
    step("rh_fetch2", 1, 0, 0, 0, PC_INC, 0, o(1, 0, PC_INC, 0, 0));
    step("rh_wait2",  0, 1, 0, 0, PC_INC, 0, o(0, 1, PC_INC, 0, 1));
    check_eq("rh_cnt1", fetch_cnt_o, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
